// File: rtl/hdmi_video_timing.sv
// Video timing generator for the ADV7513 parallel input: raster counters, pixel
// requests to a fixed-latency source, test patterns, and DE/HS/VS/RGB realignment.
module hdmi_video_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2,
  parameter int CW         = 12
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iEN,
  input  logic [1:0]    iMODE,
  input  logic [23:0]   iRGB,
  output logic          oPIX_REQ,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oDE,
  output logic          oHS,
  output logic          oVS,
  output logic [23:0]   oRGB,
  output logic          oFRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_LAST_C  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG_C  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END_C  = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG_C  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END_C  = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] BAR_END_C = CW'(BAR_W - 1);

  typedef struct packed {
    logic        req;
    logic        hs;
    logic        vs;
    logic        first;
    logic [1:0]  mode;
    logic [23:0] pat;
  } pipe_t;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [CW-1:0] r_bar_pix;
  logic [2:0]    r_bar_idx;
  logic [1:0]    r_mode;
  pipe_t         r_pipe [0:PIPE_DELAY];

  logic          w_h_last;
  logic          w_v_last;
  logic          w_sof;
  logic [1:0]    w_mode;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic [23:0]   w_bar_rgb;
  logic [23:0]   w_grid_rgb;
  logic [23:0]   w_pat;
  pipe_t         w_tail;

  assign w_h_last = (r_h_cnt == H_LAST_C);
  assign w_v_last = (r_v_cnt == V_LAST_C);
  assign w_sof    = iEN && (r_h_cnt == '0) && (r_v_cnt == '0);
  // The first pixel of a frame already uses the mode being latched on this edge.
  assign w_mode   = w_sof ? iMODE : r_mode;
  assign w_active = iEN && (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign w_hs     = iEN && (r_h_cnt >= HS_BEG_C) && (r_h_cnt < HS_END_C);
  assign w_vs     = iEN && (r_v_cnt >= VS_BEG_C) && (r_v_cnt < VS_END_C);

  // Bar order white..black maps onto R=~idx[1], G=~idx[2], B=~idx[0].
  assign w_bar_rgb  = {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};
  assign w_grid_rgb = ((r_h_cnt[3:0] == 4'd0) || (r_v_cnt[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;

  always_comb begin
    w_pat = 24'h000000;
    case (w_mode)
      2'd1:    w_pat = w_bar_rgb;
      2'd2:    w_pat = w_grid_rgb;
      default: w_pat = 24'h000000;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_pix <= '0;
      r_bar_idx <= '0;
      r_mode    <= '0;
    end else if (!iEN) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else begin
      if (w_sof) r_mode <= iMODE;
      if (w_h_last) begin
        r_h_cnt   <= '0;
        r_v_cnt   <= w_v_last ? '0 : r_v_cnt + 1'b1;
        r_bar_pix <= '0;
        r_bar_idx <= '0;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
        if (r_bar_pix == BAR_END_C) begin
          r_bar_pix <= '0;
          r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_pix <= r_bar_pix + 1'b1;
        end
      end
    end
  end

  // Stage 0 is the decode register; stages 1..PIPE_DELAY cover the source latency.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i <= PIPE_DELAY; i++) r_pipe[i] <= '0;
      oX <= '0;
      oY <= '0;
    end else begin
      r_pipe[0] <= '{req: w_active, hs: w_hs, vs: w_vs, first: w_sof,
                     mode: w_mode, pat: w_pat};
      for (int i = 1; i <= PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      oX <= r_h_cnt;
      oY <= r_v_cnt;
    end
  end

  assign oPIX_REQ = r_pipe[0].req;
  assign w_tail   = r_pipe[PIPE_DELAY];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDE          <= 1'b0;
      oHS          <= ~HS_POL;
      oVS          <= ~VS_POL;
      oRGB         <= 24'h000000;
      oFRAME_START <= 1'b0;
    end else begin
      oDE          <= w_tail.req;
      oHS          <= w_tail.hs ? HS_POL : ~HS_POL;
      oVS          <= w_tail.vs ? VS_POL : ~VS_POL;
      oFRAME_START <= w_tail.req & w_tail.first;
      if (!w_tail.req)
        oRGB <= 24'h000000;
      else if (w_tail.mode == 2'd0)
        oRGB <= iRGB;
      else
        oRGB <= w_tail.pat;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench for hdmi_video_timing on a reduced raster: every request is
// queued with its expected pixel and retired when the matching oDE appears.
module tb_hdmi_video_timing;

  localparam int H_A = 32, H_F = 4, H_S = 8, H_B = 4;
  localparam int V_A = 20, V_F = 2, V_S = 2, V_B = 3;
  localparam int PD = 2, CW = 12;
  localparam int H_T = H_A + H_F + H_S + H_B;
  localparam int V_T = V_A + V_F + V_S + V_B;
  localparam int FRAME = H_T * V_T;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iEN = 1'b0;
  logic [1:0]    iMODE = 2'd0;
  logic [23:0]   iRGB = 24'h0;
  logic          oPIX_REQ;
  logic [CW-1:0] oX, oY;
  logic          oDE, oHS, oVS, oFRAME_START;
  logic [23:0]   oRGB;

  hdmi_video_timing #(
    .H_ACTIVE(H_A), .H_FRONT(H_F), .H_SYNC(H_S), .H_BACK(H_B),
    .V_ACTIVE(V_A), .V_FRONT(V_F), .V_SYNC(V_S), .V_BACK(V_B),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(PD), .CW(CW)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iMODE(iMODE), .iRGB(iRGB),
    .oPIX_REQ(oPIX_REQ), .oX(oX), .oY(oY), .oDE(oDE), .oHS(oHS), .oVS(oVS),
    .oRGB(oRGB), .oFRAME_START(oFRAME_START)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          cyc;
    int          x;
    int          y;
    int          mode;
    logic [23:0] rgb;
    logic        first;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] src_q[$];
  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / (H_A / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input int x, input int y, input int m);
    case (m)
      0: return {8'(x), 8'(y), 8'h5A};
      1: return bar_rgb(x);
      2: return ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  int   cyc = 0, exp_mode = 0, frames = 0, de_total = 0;
  logic [1:0] imode_q = 2'd0;
  bit   meas_en = 1'b0, frame_seen = 1'b0;
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;
  int   hs_fall = -1, vs_fall = -1, de_run = 0, de_lines = 0;

  always @(posedge iCLK) imode_q = iMODE;

  always @(negedge iCLK) begin
    exp_t e;
    cyc++;
    if (!iRST_N) begin
      sb_q.delete();
      src_q.delete();
      exp_mode = 0;
      iRGB = 24'h0;
    end else begin
      if (oDE) begin
        de_total++;
        if (sb_q.size() == 0) begin
          chk("de_spurious", {31'd0, oDE}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("de_latency", cyc - e.cyc, PD + 1);
          chk("rgb", oRGB, e.rgb);
          chk("frame_start", oFRAME_START, e.first);
          if (e.mode == 1 && e.y == 0 && e.x == 0)       chk("bar_x0", oRGB, 24'hFFFFFF);
          if (e.mode == 1 && e.y == 0 && e.x == H_A / 8) chk("bar_x1st", oRGB, 24'hFFFF00);
          if (e.mode == 1 && e.y == 0 && e.x == H_A - 1) chk("bar_last", oRGB, 24'h000000);
          if (e.mode == 2 && e.y == 5 && e.x == 16)      chk("grid_16_5", oRGB, 24'hFFFFFF);
          if (e.mode == 2 && e.y == 5 && e.x == 17)      chk("grid_17_5", oRGB, 24'h000000);
        end
      end else begin
        chk("idle_out", {oFRAME_START, oRGB}, 25'd0);
      end
      if (sb_q.size() > 0 && cyc - sb_q[0].cyc > PD + 1) begin
        chk("de_missing", cyc - sb_q[0].cyc, PD + 1);
        e = sb_q.pop_front();
      end
      if (oPIX_REQ) begin
        if (oX == 0 && oY == 0) exp_mode = int'(imode_q);
        e.cyc = cyc; e.x = int'(oX); e.y = int'(oY); e.mode = exp_mode;
        e.rgb = exp_rgb(e.x, e.y, exp_mode);
        e.first = (oX == 0 && oY == 0);
        sb_q.push_back(e);
      end
      src_q.push_back({oX[7:0], oY[7:0], 8'h5A});
      if (src_q.size() > PD) iRGB = src_q.pop_front();
      if (oFRAME_START) frames++;
      if (meas_en) begin
        if (prev_hs && !oHS) begin
          if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, H_T);
          hs_fall = cyc;
        end
        if (!prev_hs && oHS && hs_fall >= 0) chk("hs_width", cyc - hs_fall, H_S);
        if (prev_vs && !oVS) begin
          if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, FRAME);
          vs_fall = cyc;
        end
        if (!prev_vs && oVS && vs_fall >= 0) chk("vs_width", cyc - vs_fall, V_S * H_T);
        if (oDE) de_run++;
        else if (prev_de) begin
          chk("de_per_line", de_run, H_A);
          de_run = 0;
          de_lines++;
        end
        if (oFRAME_START) begin
          if (frame_seen) chk("de_lines", de_lines, V_A);
          frame_seen = 1'b1;
          de_lines = 0;
        end
      end else begin
        hs_fall = -1; vs_fall = -1; de_run = 0; de_lines = 0; frame_seen = 1'b0;
      end
    end
    prev_hs = oHS; prev_vs = oVS; prev_de = oDE;
  end

  task automatic wait_frames(input int n);
    int start;
    start = frames;
    for (int k = 0; k < n * FRAME + 100 && frames < start + n; k++) @(negedge iCLK);
    #1 chk("wait_frames", frames - start, n);
  endtask

  task automatic wait_req(input int x, input int y);
    int k;
    for (k = 0; k < 2 * FRAME; k++) begin
      @(negedge iCLK);
      if (oPIX_REQ && oX == CW'(x) && oY == CW'(y)) break;
    end
    chk("wait_req", {oPIX_REQ, 4'(y), 4'(x)}, {1'b1, 4'(y), 4'(x)});
  endtask

  initial begin
    int k, d0;
    repeat (3) @(negedge iCLK);
    #1;
    $display("step: reset state");
    chk("rst_de", oDE, 1'b0);
    chk("rst_hs", oHS, 1'b1);
    chk("rst_vs", oVS, 1'b1);
    chk("rst_rgb", oRGB, 24'h0);
    chk("rst_req", oPIX_REQ, 1'b0);
    chk("rst_fs", oFRAME_START, 1'b0);
    chk("rst_xy", {oX, oY}, 24'h0);

    $display("step: free run two frames, mode 0 pass-through");
    frames = 0; de_total = 0; meas_en = 1'b1;
    @(posedge iCLK); #3 iRST_N = 1'b1; iEN = 1'b1;
    repeat (2 * FRAME) @(negedge iCLK);
    #1;
    chk("frames_2", frames, 2);
    chk("de_total_2", de_total, 2 * H_A * V_A);

    $display("step: colour bars");
    @(negedge iCLK) iMODE = 2'd1;
    wait_frames(2);

    $display("step: grid selected mid-frame");
    wait_req(3, 10);
    iMODE = 2'd2;
    wait_frames(2);

    $display("step: enable dropped mid-line");
    wait_req(10, 5);
    iEN = 1'b0; meas_en = 1'b0;
    #1 d0 = de_total;
    repeat (PD + 10) @(negedge iCLK);
    #1;
    chk("drain_de", de_total - d0, PD + 1);
    chk("drain_q", sb_q.size(), 0);
    chk("idle_req", oPIX_REQ, 1'b0);
    chk("idle_sync", {oHS, oVS}, 2'b11);

    $display("step: re-enable");
    iMODE = 2'd0;
    @(negedge iCLK) iEN = 1'b1;
    for (k = 1; k < 40; k++) begin
      @(negedge iCLK);
      if (oFRAME_START) break;
    end
    chk("reen_latency", k, PD + 2);
    chk("reen_de", oDE, 1'b1);
    wait_frames(1);

    $display("step: reset pulse mid-line");
    for (k = 0; k < FRAME && !oDE; k++) @(negedge iCLK);
    chk("pre_rst_de", oDE, 1'b1);
    @(posedge iCLK); #3 iRST_N = 1'b0;
    #1;
    chk("arst_de", oDE, 1'b0);
    chk("arst_sync", {oHS, oVS}, 2'b11);
    chk("arst_rgb", oRGB, 24'h0);
    chk("arst_req", oPIX_REQ, 1'b0);
    repeat (2) @(posedge iCLK);
    #3 iRST_N = 1'b1;
    for (k = 1; k < 20; k++) begin
      @(negedge iCLK);
      if (oPIX_REQ) break;
    end
    chk("rst_restart_lat", k, 2);
    chk("rst_restart_xy", {oX, oY}, 24'h0);
    wait_frames(1);
    repeat (10) @(negedge iCLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Parametrised video timing and pixel-alignment block that drives the ADV7513 HDMI transmitter's parallel RGB/DE/HS/VS inputs.
- Successor to the fixed 640x480 pattern generator. Resolution, porches and sync polarity are set by parameters.
- Issues pixel requests with coordinates to a pixel source with a known read latency (e.g. CHIP8 framebuffer), then re-aligns the returned RGB with DE/HS/VS.
- Selectable built-in test patterns allow HDMI bring-up without a core.

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be divisible by 8
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, active level of oHS (0 = active-low)
- VS_POL, 0, active level of oVS
- PIPE_DELAY, 2, pixel-source latency in cycles from oPIX_REQ to valid iRGB; legal range 1..8
- CW, 12, coordinate/counter width

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST_N  in  1  asynchronous active-low reset
- iEN  in  1  timing run enable
- iMODE  in  2  0 = pass-through iRGB, 1 = colour bars, 2 = grid, 3 = solid black
- iRGB  in  24  pixel from source, {R,G,B}, valid PIPE_DELAY cycles after the matching oPIX_REQ
- oPIX_REQ  out  1  pixel request (active region)
- oX  out  CW  requested column, valid when oPIX_REQ=1
- oY  out  CW  requested row, valid when oPIX_REQ=1
- oDE  out  1  data enable to transmitter
- oHS  out  1  horizontal sync
- oVS  out  1  vertical sync
- oRGB  out  24  pixel data to transmitter
- oFRAME_START  out  1  one-cycle pulse coincident with the first oDE of each frame

Behaviour:
- Reset (asynchronous): h_cnt=0, v_cnt=0, oPIX_REQ=0, oX=0, oY=0, oDE=0, oRGB=0, oFRAME_START=0, oHS=!HS_POL, oVS=!VS_POL. The whole delay line is cleared to the inactive state. Latched mode resets to 0.
- Totals: H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Counters (cycle with iEN=1): h_cnt increments; h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt. v_cnt wraps V_TOTAL-1 -> 0. With iEN=0 both counters are forced to 0.
- Decode stage (registered, 1 cycle after count):
  - oPIX_REQ = iEN & h<H_ACTIVE & v<V_ACTIVE; oX=h, oY=v.
  - Internal hs = h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - Internal vs = v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
  - Both hs and vs are gated by iEN.
- Mode latch: iMODE is sampled only when iEN=1 and h=0, v=0. A mode change mid-frame takes effect at the next frame.
- Patterns are computed at the decode stage:
  - Bars: 8 bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. Channels are 8'hFF/8'h00. The bar index comes from a sub-counter reset at h=0, not from a divider.
  - Grid: white where x[3:0]==0 or y[3:0]==0, else black.
  - Solid: 24'h000000.
- Alignment: req/hs/vs/pattern/frame-first flags pass through a PIPE_DELAY-stage shift register. At cycle t+PIPE_DELAY+1 for a request at cycle t:
  - oDE = delayed req.
  - oHS = delayed hs ? HS_POL : !HS_POL; oVS likewise with VS_POL.
  - oRGB = (mode 0) ? iRGB registered at t+PIPE_DELAY : delayed pattern.
  - oRGB = 0 whenever the delayed req = 0.
- Latency: oDE follows oPIX_REQ by exactly PIPE_DELAY+1 cycles.
- Frame start: oFRAME_START=1 when oDE corresponds to x=0, y=0; otherwise 0.
- iEN falling: counters return to 0 next edge. Already-issued requests drain through the pipeline normally. Outputs become inactive PIPE_DELAY+1 cycles later.
- iEN rising: a request for (0,0) appears on the following edge. A fresh frame starts.
- Reset mid-frame: all outputs inactive immediately (asynchronous). No partial line is emitted after release.

Test Plan:
- Defaults, iEN=1, mode 0, 2 frames:
  - HS period 800 cycles, low for 96; VS period 420000 cycles, low for 1600.
  - 640 DE cycles/line, 480 DE lines/frame.
- PIPE_DELAY=2, source model returns iRGB={oX[7:0],oY[7:0],8'h5A} two cycles after request:
  - Every oDE cycle carries the matching {x,y,5A}.
  - oDE lags oPIX_REQ by exactly 3 cycles.
- Mode 1: line 0 pixels 0..79 = FFFFFF, 80..159 = FFFF00, ..., 560..639 = 000000.
- Mode 2: oRGB=FFFFFF at x=16, y=5; oRGB=000000 at x=17, y=5. iMODE changed mid-frame: no change until next oFRAME_START.
- iEN deasserted at h=300, v=100:
  - DE stops after draining exactly the requests already issued.
  - On re-enable, the first oDE follows with oFRAME_START=1 after PIPE_DELAY+2 cycles.
- iRST_N pulsed low mid-line:
  - oDE=0, oHS=1, oVS=1, oRGB=0 asynchronously.
  - After release, the sequence restarts at (0,0).
- HS_POL=1, VS_POL=1, H_ACTIVE=320 build: sync pulses active-high; HS period 480.
